// File: rtl/writeback_serializer.sv
// Writeback serializer: queues writeback-mux results and drains them onto one GPR port and one CR/XER port.
// Optional feature macro WB_BYPASS_EN: an entry offered while the block is empty and idle skips the FIFO.
module writeback_serializer #(
  parameter int regWidth     = 5,
  parameter int dataWidth    = 64,
  parameter int fifoDepth    = 4,
  parameter int FXUnitCode   = 0,
  parameter int LdStUnitCode = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [2:0]           functionalUnitCode_i,
  input  logic                 reg1WritebackEnable_i,
  input  logic                 reg2WritebackEnable_i,
  input  logic [regWidth-1:0]  reg1WritebackAddress_i,
  input  logic [regWidth-1:0]  reg2WritebackAddress_i,
  input  logic [dataWidth-1:0] reg1WritebackVal_i,
  input  logic [dataWidth-1:0] reg2WritebackVal_i,
  output logic                 ready_o,
  output logic                 gprWriteEnable_o,
  output logic [regWidth-1:0]  gprWriteAddress_o,
  output logic [dataWidth-1:0] gprWriteVal_o,
  output logic                 crWriteEnable_o,
  output logic [regWidth-1:0]  crWriteBits_o,
  output logic [dataWidth-1:0] xerWriteVal_o,
  output logic                 overflow_o,
  output logic                 empty_o
);
  localparam int PtrW = $clog2(fifoDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [2:0]      FX_CODE = 3'(FXUnitCode);
  localparam logic [2:0]      LS_CODE = 3'(LdStUnitCode);
  localparam logic [CntW-1:0] DEPTH   = CntW'(fifoDepth);

  typedef struct packed {
    logic [2:0]           code;
    logic                 en1;
    logic                 en2;
    logic [regWidth-1:0]  a1;
    logic [regWidth-1:0]  a2;
    logic [dataWidth-1:0] v1;
    logic [dataWidth-1:0] v2;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, SECOND = 2'd2} state_t;

  entry_t               fifo_mem_r [fifoDepth];
  logic [PtrW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CntW-1:0]      count_r, count_next_s;
  logic                 ready_r, overflow_r, empty_r;
  state_t               state_r;
  entry_t               cur_r, in_s, head_s;
  logic                 offer_s, bypass_s, push_s, pop_s, cur_dual_s;
  logic                 gpr_en_r, cr_en_r;
  logic [regWidth-1:0]  gpr_addr_r, cr_bits_r;
  logic [dataWidth-1:0] gpr_val_r, xer_val_r;

  assign head_s = fifo_mem_r[rd_ptr_r];

  // Accept / bypass / pop decisions and next occupancy
  always_comb begin
    in_s.code = functionalUnitCode_i;
    in_s.en1  = reg1WritebackEnable_i;
    in_s.en2  = reg2WritebackEnable_i;
    in_s.a1   = reg1WritebackAddress_i;
    in_s.a2   = reg2WritebackAddress_i;
    in_s.v1   = reg1WritebackVal_i;
    in_s.v2   = reg2WritebackVal_i;
    offer_s   = reg1WritebackEnable_i | reg2WritebackEnable_i;
`ifdef WB_BYPASS_EN
    bypass_s  = offer_s & ready_r & (state_r == IDLE) & (count_r == '0);
`else
    bypass_s  = 1'b0;
`endif
    push_s     = offer_s & ready_r & ~bypass_s;
    cur_dual_s = (cur_r.code == LS_CODE) & cur_r.en1 & cur_r.en2;
    // A dual-GPR entry holds the drain for its SECOND cycle before the next pop
    pop_s = (count_r != '0) & ((state_r == IDLE) | (state_r == SECOND) |
                               ((state_r == ISSUE) & ~cur_dual_s));
    count_next_s = count_r + CntW'(push_s) - CntW'(pop_s);
  end

  // FIFO storage, pointers, occupancy, ready and sticky overflow
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < fifoDepth; i++) fifo_mem_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      ready_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= in_s;
        wr_ptr_r             <= wr_ptr_r + PtrW'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PtrW'(1'b1);
      count_r <= count_next_s;
      ready_r <= (count_next_s < DEPTH);
      if (offer_s && !ready_r) overflow_r <= 1'b1;
    end
  end

  // Drain FSM: loads the issue register and drives the registered write ports
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= IDLE;
      cur_r      <= '0;
      gpr_en_r   <= 1'b0;
      gpr_addr_r <= '0;
      gpr_val_r  <= '0;
      cr_en_r    <= 1'b0;
      cr_bits_r  <= '0;
      xer_val_r  <= '0;
      empty_r    <= 1'b1;
    end else begin
      gpr_en_r <= 1'b0;
      cr_en_r  <= 1'b0;
      empty_r  <= (state_r == IDLE) & (count_r == '0) & ~push_s & ~bypass_s;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            cur_r   <= head_s;
            state_r <= ISSUE;
          end else if (bypass_s) begin
            cur_r   <= in_s;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (cur_r.code == FX_CODE) begin
            if (cur_r.en1) begin
              gpr_en_r   <= 1'b1;
              gpr_addr_r <= cur_r.a1;
              gpr_val_r  <= cur_r.v1;
            end
            if (cur_r.en2) begin
              cr_en_r   <= 1'b1;
              cr_bits_r <= cur_r.a2;
              xer_val_r <= cur_r.v2;
            end
          end else if (cur_r.code == LS_CODE) begin
            if (cur_r.en1) begin
              gpr_en_r   <= 1'b1;
              gpr_addr_r <= cur_r.a1;
              gpr_val_r  <= cur_r.v1;
            end else if (cur_r.en2) begin
              gpr_en_r   <= 1'b1;
              gpr_addr_r <= cur_r.a2;
              gpr_val_r  <= cur_r.v2;
            end
          end else if (cur_r.en1) begin
            gpr_en_r   <= 1'b1;
            gpr_addr_r <= cur_r.a1;
            gpr_val_r  <= cur_r.v1;
          end
          if (cur_dual_s) begin
            state_r <= SECOND;
          end else if (pop_s) begin
            cur_r   <= head_s;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        SECOND: begin
          gpr_en_r   <= 1'b1;
          gpr_addr_r <= cur_r.a2;
          gpr_val_r  <= cur_r.v2;
          if (pop_s) begin
            cur_r   <= head_s;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign ready_o           = ready_r;
  assign overflow_o        = overflow_r;
  assign empty_o           = empty_r;
  assign gprWriteEnable_o  = gpr_en_r;
  assign gprWriteAddress_o = gpr_addr_r;
  assign gprWriteVal_o     = gpr_val_r;
  assign crWriteEnable_o   = cr_en_r;
  assign crWriteBits_o     = cr_bits_r;
  assign xerWriteVal_o     = xer_val_r;

endmodule
